// File: rtl/disp_pkg.sv
// Shared types and helpers for the display page arbiter.
// Holds no tunable parameters; those stay on each instance.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } disp_state_t;

    localparam int SRC_VAL_W = 32;

    // LSB position of source idx inside the packed value bus
    function automatic int val_lsb(input int idx);
        return idx * SRC_VAL_W;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first set bit of req at (incl_start) or strictly after
// start, walking upward with wrap-around.
import disp_pkg::*;

module rr_next_sel #(
    parameter  int N_SRC = 4,
    localparam int IW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    start,
    input  logic             incl_start,
    output logic             found,
    output logic [IW-1:0]    sel
);

    localparam int SW = IW + 1;

    logic [SW-1:0] sum_s;
    logic          hit_s;

    // Offsets are walked from farthest to nearest so the nearest hit is written last
    always_comb begin
        found = 1'b0;
        sel   = start;
        sum_s = '0;
        hit_s = 1'b0;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            sum_s = {1'b0, start} + SW'(off);
            sum_s = (sum_s >= SW'(N_SRC)) ? (sum_s - SW'(N_SRC)) : sum_s;
            hit_s = ((off != 0) || incl_start) && req[sum_s[IW-1:0]];
            found = found | hit_s;
            sel   = hit_s ? sum_s[IW-1:0] : sel;
        end
    end

endmodule

// File: rtl/disp_page_arbiter.sv
// Time-shares the 8-digit display between requesting sources in round-robin
// pages, with an alert strobe that forces one source on screen for a while.
import disp_pkg::*;

module disp_page_arbiter #(
    parameter int N_SRC      = 4,
    parameter int CYC_PER_MS = 100_000,
    parameter int DWELL_MS   = 1000,
    parameter int ALERT_MS   = 3000
) (
    input  logic                       clk_100MHz_i,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           req_i,
    input  logic [32*N_SRC-1:0]        val_i,
    input  logic                       alert_i,
    input  logic [$clog2(N_SRC)-1:0]   alert_src_i,
    input  logic                       freeze_i,
    output logic [15:0]                cnt_val_1_o,
    output logic [15:0]                cnt_val_2_o,
    output logic [$clog2(N_SRC)-1:0]   page_o,
    output logic                       page_vld_o,
    output logic                       alert_act_o,
    output logic                       page_chg_o
);

    localparam int IW     = $clog2(N_SRC);
    localparam int PW     = $clog2(CYC_PER_MS + 1);
    localparam int MAX_MS = (DWELL_MS > ALERT_MS) ? DWELL_MS : ALERT_MS;
    localparam int CW     = $clog2(MAX_MS + 1);

    disp_state_t    state_r, state_s;
    logic [IW-1:0]  page_s;
    logic [IW-1:0]  rr_ptr_r;
    logic [IW-1:0]  saved_r, saved_s;
    logic           saved_vld_r, saved_vld_s;
    logic           load_s, restart_s;
    logic [PW-1:0]  presc_r;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  lim_s;
    logic           tick_s, expired_s;
    logic           rr_found_s, af_found_s;
    logic [IW-1:0]  rr_sel_s, af_sel_s, after_start_s;
    logic [31:0]    src_val [N_SRC];
    logic [IW-1:0]  rr_inc_s;

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign src_val[k] = val_i[val_lsb(k) +: SRC_VAL_W];
    end

    // Alert resume searches after the interrupted page, all other cases after the current one
    assign after_start_s = (state_r == ALERT) ? saved_r : page_o;

    rr_next_sel #(.N_SRC(N_SRC)) u_sel_rr (
        .req        (req_i),
        .start      (rr_ptr_r),
        .incl_start (1'b1),
        .found      (rr_found_s),
        .sel        (rr_sel_s)
    );

    rr_next_sel #(.N_SRC(N_SRC)) u_sel_after (
        .req        (req_i),
        .start      (after_start_s),
        .incl_start (1'b0),
        .found      (af_found_s),
        .sel        (af_sel_s)
    );

    assign tick_s    = (presc_r == PW'(CYC_PER_MS - 1));
    assign lim_s     = (state_r == ALERT) ? CW'(ALERT_MS) : CW'(DWELL_MS);
    // A saturated counter keeps expiry asserted while a frozen page is held
    assign expired_s = (cnt_r == lim_s) || (tick_s && (cnt_r == (lim_s - CW'(1))));
    assign rr_inc_s  = (page_s == IW'(N_SRC - 1)) ? '0 : (page_s + IW'(1));

    // Next-state and page-load decision; alert beats request drop beats expiry
    always_comb begin
        state_s     = state_r;
        page_s      = page_o;
        load_s      = 1'b0;
        restart_s   = 1'b0;
        saved_s     = saved_r;
        saved_vld_s = saved_vld_r;
        case (state_r)
            IDLE: begin
                if (alert_i) begin
                    state_s     = ALERT;
                    page_s      = alert_src_i;
                    load_s      = 1'b1;
                    saved_vld_s = 1'b0;
                end else if (rr_found_s) begin
                    state_s = SHOW;
                    page_s  = rr_sel_s;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHOW: begin
                if (alert_i) begin
                    state_s     = ALERT;
                    page_s      = alert_src_i;
                    load_s      = 1'b1;
                    saved_s     = page_o;
                    saved_vld_s = 1'b1;
                end else if (!req_i[page_o]) begin
                    if (af_found_s) begin
                        page_s = af_sel_s;
                        load_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (expired_s && !freeze_i) begin
                    if (af_found_s) begin
                        page_s = af_sel_s;
                        load_s = 1'b1;
                    end else begin
                        restart_s = 1'b1;
                    end
                end else begin
                    state_s = SHOW;
                end
            end
            ALERT: begin
                if (alert_i) begin
                    page_s = alert_src_i;
                    load_s = 1'b1;
                end else if (expired_s) begin
                    if (saved_vld_r && req_i[saved_r]) begin
                        state_s = SHOW;
                        page_s  = saved_r;
                        load_s  = 1'b1;
                    end else if (saved_vld_r && af_found_s) begin
                        state_s = SHOW;
                        page_s  = af_sel_s;
                        load_s  = 1'b1;
                    end else if (!saved_vld_r && rr_found_s) begin
                        state_s = SHOW;
                        page_s  = rr_sel_s;
                        load_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = ALERT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, saved page and round-robin pointer
    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            saved_r     <= '0;
            saved_vld_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            state_r     <= state_s;
            saved_r     <= saved_s;
            saved_vld_r <= saved_vld_s;
            rr_ptr_r    <= load_s ? rr_inc_s : rr_ptr_r;
        end
    end

    // Millisecond prescaler and dwell/alert counter, both restarted on a page load
    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            cnt_r   <= '0;
        end else if (load_s || restart_s) begin
            presc_r <= '0;
            cnt_r   <= '0;
        end else begin
            presc_r <= tick_s ? '0 : (presc_r + PW'(1));
            if (tick_s && (cnt_r < lim_s)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered outputs; the shown value tracks val_i live while a page is valid
    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            page_o      <= '0;
            page_chg_o  <= 1'b0;
            page_vld_o  <= 1'b0;
            alert_act_o <= 1'b0;
            cnt_val_1_o <= 16'h0000;
            cnt_val_2_o <= 16'h0000;
        end else begin
            page_o      <= page_s;
            page_chg_o  <= load_s;
            page_vld_o  <= (state_s != IDLE);
            alert_act_o <= (state_s == ALERT);
            if (state_s != IDLE) begin
                cnt_val_1_o <= src_val[page_s][31:16];
                cnt_val_2_o <= src_val[page_s][15:0];
            end else begin
                cnt_val_1_o <= 16'h0000;
                cnt_val_2_o <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_disp_page_arbiter.sv
// Directed, table-driven bench for disp_page_arbiter with a few hand-written
// sequences for live values and asynchronous reset.
module tb_disp_page_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] val;
    logic         alert;
    logic [1:0]   asrc;
    logic         freeze;
    logic [15:0]  c1, c2;
    logic [1:0]   page;
    logic         vld, act, chg;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [3:0] req;
        logic       frz;
        logic       alr;
        logic [1:0] asrc;
        logic [1:0] page;
        logic       chg;
        logic       vld;
        logic       act;
        string      name;
    } vec_t;

    vec_t vecs[$];

    disp_page_arbiter #(
        .N_SRC(4), .CYC_PER_MS(10), .DWELL_MS(3), .ALERT_MS(5)
    ) dut (
        .clk_100MHz_i (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .val_i        (val),
        .alert_i      (alert),
        .alert_src_i  (asrc),
        .freeze_i     (freeze),
        .cnt_val_1_o  (c1),
        .cnt_val_2_o  (c2),
        .page_o       (page),
        .page_vld_o   (vld),
        .alert_act_o  (act),
        .page_chg_o   (chg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hi(input int k);
        return 16'(16'h1100 * (k + 1));
    endfunction

    function automatic logic [15:0] lo(input int k);
        return 16'(16'h000A + k);
    endfunction

    function automatic void add(input int cyc, input logic [3:0] r, input logic f,
                                input logic a, input logic [1:0] s, input logic [1:0] p,
                                input logic ch, input logic v, input logic ac, input string nm);
        vec_t t;
        t.cyc = cyc; t.req = r; t.frz = f; t.alr = a; t.asrc = s;
        t.page = p; t.chg = ch; t.vld = v; t.act = ac; t.name = nm;
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input logic [36:0] exp);
        logic [36:0] got;
        got = {page, chg, vld, act, c1, c2};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got page=%0d chg=%b vld=%b act=%b val=%h_%h, expected page=%0d chg=%b vld=%b act=%b val=%h_%h",
                     nm, got[36:35], got[34], got[33], got[32], got[31:16], got[15:0],
                     exp[36:35], exp[34], exp[33], exp[32], exp[31:16], exp[15:0]);
        end
    endtask

    initial begin
        logic [36:0] e;
        rst_n = 1'b0; req = 4'b0000; alert = 1'b0; asrc = 2'd0; freeze = 1'b0;
        for (int k = 0; k < 4; k++) val[k*32 +: 32] = {hi(k), lo(k)};

        // rotation 0,1,3,0 every 30 cycles
        add( 1, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "rot_load0");
        add( 1, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "rot_hold0");
        add(28, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "rot_pre1");
        add( 1, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, "rot_load1");
        add(30, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, "rot_load3");
        add(30, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "rot_load0b");
        // single requester, restart without pulse, then drop to idle
        add( 1, 4'b0100, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, "sgl_load2");
        add(29, 4'b0100, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "sgl_pre");
        add( 1, 4'b0100, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "sgl_restart");
        add( 1, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, "drop_idle");
        // freeze across expiry, page held 45 cycles
        add( 1, 4'b0011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "frz_load0");
        add(30, 4'b0011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "frz_expiry_hold");
        add(14, 4'b0011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "frz_hold44");
        add( 1, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, "frz_release");
        // alert mid-dwell, 50 cycles, resume with fresh dwell
        add(10, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, "alr_middwell");
        add( 1, 4'b0011, 1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, "alr_load3");
        add(49, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, "alr_hold49");
        add( 1, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, "alr_resume1");
        add(29, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, "resume_pre");
        add( 1, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "resume_dwell");
        // alert extended by a second strobe 20 cycles in: 70 total
        add( 1, 4'b0011, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, "alr2_load");
        add(19, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, "alr2_hold19");
        add( 1, 4'b0011, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, "alr2_reload");
        add(49, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, "alr2_hold69");
        add( 1, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "alr2_resume0");
        // alert on the dwell-expiry cycle wins, resume the interrupted page
        add(29, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "sim_pre");
        add( 1, 4'b0011, 1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, "sim_alert_wins");
        add(49, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, "sim_hold");
        add( 1, 4'b0011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, "sim_resume0");

        repeat (3) @(negedge clk);
        check("reset_state", 37'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req; freeze = vecs[i].frz; alert = vecs[i].alr; asrc = vecs[i].asrc;
            for (int k = 0; k < vecs[i].cyc; k++) begin
                @(posedge clk);
                @(negedge clk);
                alert = 1'b0;
            end
            e = {vecs[i].page, vecs[i].chg, vecs[i].vld, vecs[i].act,
                 vecs[i].vld ? hi(int'(vecs[i].page)) : 16'h0000,
                 vecs[i].vld ? lo(int'(vecs[i].page)) : 16'h0000};
            check(vecs[i].name, e);
        end

        // live value tracking on the current page (source 0)
        val[31:16] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        check("live_val", {2'd0, 1'b0, 1'b1, 1'b0, 16'hBEEF, lo(0)});
        val[31:16] = hi(0);

        // asynchronous reset between edges, then grant from source 0 after release
        #2 rst_n = 1'b0;
        #1 check("async_reset", 37'h0);
        req = 4'b1000;
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_grant", {2'd3, 1'b1, 1'b1, 1'b0, hi(3), lo(3)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/disp_page_arbiter.md
# disp_page_arbiter

Time-shares the 8-digit seven-segment display between up to N_SRC value sources. Each source presents a pair of 16-bit values, one per 4-digit half. The block drives the `cnt_val_1_i`/`cnt_val_2_i` inputs of the display scanner (`cnt2hex`).
- Requesting sources are shown in round-robin pages of fixed dwell.
- An alert input overrides the rotation to force one source on screen for a fixed time.

## Interface
- `N_SRC`, 4: number of sources, 2..8.
- `CYC_PER_MS`, 100_000: clock cycles per millisecond tick.
- `DWELL_MS`, 1000: page dwell in ms tick counts, ≥1.
- `ALERT_MS`, 3000: alert hold in ms tick counts, ≥1.
- `clk_100MHz_i` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `req_i` in N_SRC: source k requests display time (level).
- `val_i` in 32*N_SRC: source k value at bits [32k+31:32k]. Upper 16 bits go to half 1, lower 16 bits to half 2.
- `alert_i` in 1: single-cycle alert strobe.
- `alert_src_i` in $clog2(N_SRC): source to force on an alert. Sampled only when `alert_i`=1.
- `freeze_i` in 1: suppresses dwell-expiry rotation (level).
- `cnt_val_1_o` out 16: value for display half 1.
- `cnt_val_2_o` out 16: value for display half 2.
- `page_o` out $clog2(N_SRC): index of the source currently shown.
- `page_vld_o` out 1: 1 in SHOW or ALERT.
- `alert_act_o` out 1: 1 in ALERT.
- `page_chg_o` out 1: one-cycle pulse on every page load.

## Operation
- **Reset values:** all outputs 0. State IDLE. RR pointer 0. Prescaler and dwell counters 0.
- **State IDLE:**
  - If `req_i`≠0, grant the first requester at or after the RR pointer, searching upward with wrap. Load the page and go to SHOW.
  - `alert_i` goes to ALERT.
- **State SHOW:**
  - Each cycle, `{cnt_val_1_o,cnt_val_2_o}` <= `val_i` slice of `page_o`. The value is live, not a snapshot.
  - **Dwell expiry** (DWELL_MS ticks) with `freeze_i`=0: grant the first requester strictly after `page_o` (wrap).
    - If the only requester is `page_o`, restart the dwell with no `page_chg_o`.
    - If there are no requesters, go to IDLE.
  - **Dwell expiry with `freeze_i`=1:** hold the page. The dwell counter saturates at expiry, and rotation occurs on the first cycle `freeze_i`=0.
  - **`req_i[page_o]` falls:** switch on the next edge, independent of dwell or freeze. Go to the next requester after `page_o`, else IDLE.
- **State ALERT:**
  - Show `alert_src_i` regardless of `req_i` and `freeze_i`.
  - Save the interrupted page index if the entry was from SHOW.
  - A new `alert_i` during ALERT reloads the source and restarts ALERT_MS. The saved page is unchanged.
  - On expiry, resume the saved page with a fresh dwell if it is still requesting. Otherwise take the next requester after it, else IDLE.
- **Page load:**
  - `page_o`, state, `page_chg_o`=1 and the new source's values all update on the same edge.
  - Prescaler and dwell counters clear.
  - The RR pointer is set to `page_o`+1 mod N_SRC.
- **Priority** within a cycle, highest first: `alert_i` > `req_i[page_o]` drop > dwell expiry.
- **IDLE and ALERT exit to IDLE:** `cnt_val_*_o` are forced to 0 and `page_vld_o`=0. `page_o` keeps its last value.

## Timing
- Prescaler counts 0..CYC_PER_MS-1 and emits a tick at the terminal count. It restarts on each page load.
- A page is held exactly DWELL_MS*CYC_PER_MS cycles: load at edge t, next load at edge t+DWELL_MS*CYC_PER_MS.
- An alert page is held exactly ALERT_MS*CYC_PER_MS cycles.
- Latency, `req_i` to page in IDLE: 1 cycle (`req_i` high at edge t-1 gives load at edge t).
- Latency, `alert_i` to ALERT load: 1 cycle.
- Latency, `val_i` to `cnt_val_*_o` in SHOW or ALERT: 1 cycle.
- Asserting `rst_n`=0 mid-page returns all outputs to reset values immediately, with no clock needed. The first grant after release starts from source 0.

## Structure
- **Package `disp_pkg`:**
  - `disp_state_t` enum {IDLE, SHOW, ALERT}.
  - Helper function for the value-slice index.
  - The package holds no parameters; those stay per-instance.
- **Sub-module `rr_next_sel`:**
  - Combinational.
  - Inputs: N_SRC request vector, start index, `incl_start` flag.
  - Outputs: found flag, selected index.
  - Used for the IDLE grant, dwell rotation, request-drop switching and alert resume.
- **Top level:** prescaler, dwell/alert counter, FSM and output registers.

## Test plan
Bench parameters: N_SRC=4, CYC_PER_MS=10, DWELL_MS=3, ALERT_MS=5. Dwell = 30 cycles; alert = 50 cycles.
- **Rotation:** `req_i`=4'b1011 from reset, `val_i` distinct per source → `page_o` sequence 0,1,3,0 with loads 30 cycles apart. `page_chg_o` pulses once per load. `cnt_val_1_o` equals the upper half of each source.
- **Single requester / drop:** `req_i`=4'b0100 → page 2. At dwell expiry there is no `page_chg_o` and the page stays 2. Dropping `req_i[2]` gives IDLE and outputs 0 the next cycle.
- **Freeze:** `req_i`=4'b0011, `freeze_i`=1 across expiry → page 0 holds 45 cycles. Releasing freeze gives page 1 on the next edge.
- **Alert override:** on page 1 mid-dwell, `alert_i` pulse with `alert_src_i`=3 (`req_i[3]`=0) → ALERT page 3 for 50 cycles. Then page 1 resumes with a fresh 30-cycle dwell. A second alert at cycle 20 of the ALERT extends it to 70 cycles total.
- **Simultaneous:** `alert_i` on the dwell-expiry cycle → ALERT wins. The resume target is the interrupted page.
- **Async reset:** drop `rst_n` mid-page between clock edges → all outputs 0 immediately. After release with `req_i`=4'b1000, page 3 loads 1 cycle later.
